// File: rtl/ldpc_concat_pkg.sv
// Shared types and sizing helpers for the LDPC concatenator scheduler.
// Default segment geometry matches one codeword of 144 bytes + 1x96b + 11x96b parity.
package ldpc_concat_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SEG1  = 3'd1,
        ST_SEG2  = 3'd2,
        ST_SEG3  = 3'd3,
        ST_DRAIN = 3'd4,
        ST_DONE  = 3'd5
    } state_t;

    localparam int DEF_WIDTH1     = 8;
    localparam int DEF_WIDTH2     = 96;
    localparam int DEF_WIDTH3     = 96;
    localparam int DEF_SEG1_WORDS = 144;
    localparam int DEF_SEG2_WORDS = 1;
    localparam int DEF_SEG3_WORDS = 11;
    localparam int DEF_CW_WIDTH   = 12;

    // Output bytes per codeword, with all segments expressed in WIDTH1 units.
    function automatic int cw_bytes(input int w1, input int w2, input int w3,
                                    input int s1, input int s2, input int s3);
        return s1 + (s2 * w2) / w1 + (s3 * w3) / w1;
    endfunction

    // Counter width able to hold 0 .. max_count-1, never narrower than one bit.
    function automatic int cnt_width(input int max_count);
        return (max_count > 1) ? $clog2(max_count) : 1;
    endfunction

endpackage

// File: rtl/ldpc_concat_out_monitor.sv
// Counts concatenator output beats into whole codewords and flags any beat
// arriving when no more output is expected for the current frame.
module ldpc_concat_out_monitor
    import ldpc_concat_pkg::*;
#(
    parameter int CW_BYTES = 288,
    parameter int CW_WIDTH = DEF_CW_WIDTH
) (
    input  logic                i_clock,
    input  logic                i_reset,
    input  logic                i_clear,
    input  logic                i_active,
    input  logic                i_fire,
    input  logic [CW_WIDTH-1:0] i_target,
    output logic [CW_WIDTH-1:0] o_cw_count,
    output logic                o_overrun
);

    localparam int                BYTE_W    = cnt_width(CW_BYTES);
    localparam logic [BYTE_W-1:0] BYTE_LAST = BYTE_W'(CW_BYTES - 1);

    logic [BYTE_W-1:0]   byte_cnt_q, byte_cnt_d;
    logic [CW_WIDTH-1:0] cw_count_q, cw_count_d;
    logic                overrun_q,  overrun_d;

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            byte_cnt_q <= '0;
            cw_count_q <= '0;
            overrun_q  <= 1'b0;
        end else begin
            byte_cnt_q <= byte_cnt_d;
            cw_count_q <= cw_count_d;
            overrun_q  <= overrun_d;
        end
    end

    // A fire once the target is reached is flagged but not counted, so the
    // codeword count never runs past the frame length.
    always_comb begin
        byte_cnt_d = byte_cnt_q;
        cw_count_d = cw_count_q;
        overrun_d  = overrun_q;
        if (i_clear) begin
            byte_cnt_d = '0;
            cw_count_d = '0;
            overrun_d  = 1'b0;
        end else if (i_fire) begin
            if (!i_active || (cw_count_q == i_target)) begin
                overrun_d = 1'b1;
            end else if (byte_cnt_q == BYTE_LAST) begin
                byte_cnt_d = '0;
                cw_count_d = cw_count_q + CW_WIDTH'(1);
            end else begin
                byte_cnt_d = byte_cnt_q + BYTE_W'(1);
            end
        end
    end

    assign o_cw_count = cw_count_q;
    assign o_overrun  = overrun_q;

endmodule

// File: rtl/ldpc_concat_scheduler.sv
// Sequences the three concatenator input streams one segment at a time per
// codeword and runs the start/busy/done/abort frame handshake.
module ldpc_concat_scheduler
    import ldpc_concat_pkg::*;
#(
    parameter int WIDTH1     = DEF_WIDTH1,
    parameter int WIDTH2     = DEF_WIDTH2,
    parameter int WIDTH3     = DEF_WIDTH3,
    parameter int SEG1_WORDS = DEF_SEG1_WORDS,
    parameter int SEG2_WORDS = DEF_SEG2_WORDS,
    parameter int SEG3_WORDS = DEF_SEG3_WORDS,
    parameter int CW_WIDTH   = DEF_CW_WIDTH
) (
    input  logic                i_clock,
    input  logic                i_reset,
    input  logic                i_start,
    input  logic [CW_WIDTH-1:0] i_num_codewords,
    input  logic                i_abort,
    output logic                o_busy,
    output logic                o_done,
    output logic                o_aborted,
    output logic                o_overrun,
    output logic [CW_WIDTH-1:0] o_cw_out_count,

    input  logic [WIDTH1-1:0]   i_first_data,
    input  logic                i_first_valid,
    output logic                o_first_ready,
    output logic [WIDTH1-1:0]   o_first_data,
    output logic                o_first_valid,
    input  logic                i_first_ready,

    input  logic [WIDTH2-1:0]   i_second_data,
    input  logic                i_second_valid,
    output logic                o_second_ready,
    output logic [WIDTH2-1:0]   o_second_data,
    output logic                o_second_valid,
    input  logic                i_second_ready,

    input  logic [WIDTH3-1:0]   i_third_data,
    input  logic                i_third_valid,
    output logic                o_third_ready,
    output logic [WIDTH3-1:0]   o_third_data,
    output logic                o_third_valid,
    input  logic                i_third_ready,

    input  logic                i_out_fire
);

    localparam int SEG_MAX12 = (SEG1_WORDS > SEG2_WORDS) ? SEG1_WORDS : SEG2_WORDS;
    localparam int SEG_MAX   = (SEG_MAX12 > SEG3_WORDS) ? SEG_MAX12 : SEG3_WORDS;
    localparam int BEAT_W    = cnt_width(SEG_MAX);
    localparam int CW_BYTES  = cw_bytes(WIDTH1, WIDTH2, WIDTH3,
                                        SEG1_WORDS, SEG2_WORDS, SEG3_WORDS);

    localparam logic [BEAT_W-1:0]   SEG1_LAST = BEAT_W'(SEG1_WORDS - 1);
    localparam logic [BEAT_W-1:0]   SEG2_LAST = BEAT_W'(SEG2_WORDS - 1);
    localparam logic [BEAT_W-1:0]   SEG3_LAST = BEAT_W'(SEG3_WORDS - 1);
    localparam logic [CW_WIDTH-1:0] CW_ONE    = CW_WIDTH'(1);

    state_t              state_q, state_d;
    logic [BEAT_W-1:0]   beat_cnt_q, beat_cnt_d;
    logic [CW_WIDTH-1:0] cw_rem_q, cw_rem_d;
    logic [CW_WIDTH-1:0] num_cw_q, num_cw_d;
    logic                aborted_q, aborted_d;
    logic [CW_WIDTH-1:0] cw_out_count;

    logic seg1_beat, seg2_beat, seg3_beat;
    logic seg1_last, seg2_last, seg3_last;
    logic any_beat, seg_last;
    logic start_accept, abort_take;

    assign seg1_beat = o_first_valid  & i_first_ready;
    assign seg2_beat = o_second_valid & i_second_ready;
    assign seg3_beat = o_third_valid  & i_third_ready;

    assign seg1_last = seg1_beat & (beat_cnt_q == SEG1_LAST);
    assign seg2_last = seg2_beat & (beat_cnt_q == SEG2_LAST);
    assign seg3_last = seg3_beat & (beat_cnt_q == SEG3_LAST);

    assign any_beat     = seg1_beat | seg2_beat | seg3_beat;
    assign seg_last     = seg1_last | seg2_last | seg3_last;
    assign start_accept = (state_q == ST_IDLE) & i_start & (i_num_codewords != '0);
    assign abort_take   = (state_q != ST_IDLE) & i_abort;

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        aborted_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (i_start) begin
                    state_d = (i_num_codewords != '0) ? ST_SEG1 : ST_DONE;
                end
            end
            ST_SEG1: if (seg1_last) state_d = ST_SEG2;
            ST_SEG2: if (seg2_last) state_d = ST_SEG3;
            ST_SEG3: begin
                if (seg3_last) begin
                    state_d = (cw_rem_q == CW_ONE) ? ST_DRAIN : ST_SEG1;
                end
            end
            ST_DRAIN: if (cw_out_count == num_cw_q) state_d = ST_DONE;
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
        if (abort_take) begin
            state_d   = ST_IDLE;
            aborted_d = 1'b1;
        end
    end

    always_comb begin
        o_busy         = (state_q != ST_IDLE);
        o_done         = (state_q == ST_DONE) & ~i_abort;
        o_aborted      = aborted_q;
        o_first_valid  = i_first_valid  & (state_q == ST_SEG1);
        o_first_ready  = i_first_ready  & (state_q == ST_SEG1);
        o_second_valid = i_second_valid & (state_q == ST_SEG2);
        o_second_ready = i_second_ready & (state_q == ST_SEG2);
        o_third_valid  = i_third_valid  & (state_q == ST_SEG3);
        o_third_ready  = i_third_ready  & (state_q == ST_SEG3);
    end

    assign o_first_data  = i_first_data;
    assign o_second_data = i_second_data;
    assign o_third_data  = i_third_data;

    // Beat counter is shared by all three segments; an abort freezes every
    // counter until the next accepted start reloads them.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            beat_cnt_q <= '0;
            cw_rem_q   <= '0;
            num_cw_q   <= '0;
            aborted_q  <= 1'b0;
        end else begin
            beat_cnt_q <= beat_cnt_d;
            cw_rem_q   <= cw_rem_d;
            num_cw_q   <= num_cw_d;
            aborted_q  <= aborted_d;
        end
    end

    always_comb begin
        beat_cnt_d = beat_cnt_q;
        cw_rem_d   = cw_rem_q;
        num_cw_d   = num_cw_q;
        if (start_accept) begin
            beat_cnt_d = '0;
            cw_rem_d   = i_num_codewords;
            num_cw_d   = i_num_codewords;
        end else if (!abort_take) begin
            if (any_beat) begin
                beat_cnt_d = seg_last ? '0 : beat_cnt_q + BEAT_W'(1);
            end
            if (seg3_last && (cw_rem_q != CW_ONE)) begin
                cw_rem_d = cw_rem_q - CW_ONE;
            end
        end
    end

    ldpc_concat_out_monitor #(
        .CW_BYTES (CW_BYTES),
        .CW_WIDTH (CW_WIDTH)
    ) u_out_monitor (
        .i_clock    (i_clock),
        .i_reset    (i_reset),
        .i_clear    (start_accept),
        .i_active   (state_q != ST_IDLE),
        .i_fire     (i_out_fire),
        .i_target   (num_cw_q),
        .o_cw_count (cw_out_count),
        .o_overrun  (o_overrun)
    );

    assign o_cw_out_count = cw_out_count;

endmodule

// File: tb/tb_ldpc_concat_scheduler.sv
// Directed bench for ldpc_concat_scheduler with a frame-level reference model
// checked every cycle, plus hand-computed totals per scenario.
module tb_ldpc_concat_scheduler;

    localparam int W1 = 8;
    localparam int W2 = 96;
    localparam int W3 = 96;
    localparam int CWW = 12;
    localparam int CW_BEATS = 156;   // 144 + 1 + 11 stream beats per codeword
    localparam int CW_BYTES = 288;   // 144 + 1*12 + 11*12 output bytes per codeword

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic           rst, start, abort, out_fire;
    logic [CWW-1:0] num;
    logic           busy, done, aborted, overrun;
    logic [CWW-1:0] cw_out;
    logic [W1-1:0]  d1i, d1o;
    logic [W2-1:0]  d2i, d2o;
    logic [W3-1:0]  d3i, d3o;
    logic           v1i, r1o, v1o, r1i;
    logic           v2i, r2o, v2o, r2i;
    logic           v3i, r3o, v3o, r3i;

    ldpc_concat_scheduler dut (
        .i_clock(clk), .i_reset(rst), .i_start(start), .i_num_codewords(num),
        .i_abort(abort), .o_busy(busy), .o_done(done), .o_aborted(aborted),
        .o_overrun(overrun), .o_cw_out_count(cw_out),
        .i_first_data(d1i), .i_first_valid(v1i), .o_first_ready(r1o),
        .o_first_data(d1o), .o_first_valid(v1o), .i_first_ready(r1i),
        .i_second_data(d2i), .i_second_valid(v2i), .o_second_ready(r2o),
        .o_second_data(d2o), .o_second_valid(v2o), .i_second_ready(r2i),
        .i_third_data(d3i), .i_third_valid(v3i), .o_third_ready(r3o),
        .o_third_data(d3o), .o_third_valid(v3o), .i_third_ready(r3i),
        .i_out_fire(out_fire)
    );

    int checks = 0;
    int errors = 0;

    typedef enum {M_IDLE, M_RUN, M_DONE} mode_t;
    mode_t m_mode = M_IDLE;
    int m_n = 0, m_b = 0, m_f = 0, m_cw = 0;
    bit m_ovr = 1'b0, m_abt = 1'b0;

    int cnt1 = 0, cnt2 = 0, cnt3 = 0, done_cnt = 0, abt_cnt = 0, busy_cyc = 0;
    int cyc = 0, last_fire_cyc = 0, done_cyc = 0, start_cyc = 0;
    int b1, b2, b3, bd, ba, bb;
    bit run_cmp = 1'b0, bp = 1'b0, fire_rand = 1'b0;
    int fire_left = 0;

    task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Model: a frame is a run of CW_BEATS*N stream beats; the active stream is
    // fixed by the position within the current codeword.
    task automatic cycle_check();
        int seg, k, old_cw;
        bit beat;
        seg = 0;
        if (m_mode == M_RUN && m_b < CW_BEATS * m_n) begin
            k = m_b % CW_BEATS;
            seg = (k < 144) ? 1 : ((k < 145) ? 2 : 3);
        end
        chk("busy", busy, m_mode != M_IDLE);
        chk("done", done, (m_mode == M_DONE) && !abort);
        chk("aborted", aborted, m_abt);
        chk("overrun", overrun, m_ovr);
        chk("cw_out_count", cw_out, m_cw);
        chk("first_valid", v1o, v1i && seg == 1);
        chk("first_ready", r1o, r1i && seg == 1);
        chk("second_valid", v2o, v2i && seg == 2);
        chk("second_ready", r2o, r2i && seg == 2);
        chk("third_valid", v3o, v3i && seg == 3);
        chk("third_ready", r3o, r3i && seg == 3);
        chk("first_data", d1o, d1i);
        chk("second_data", d2o, d2i);
        chk("third_data", d3o, d3i);
        chk("one_gated_valid", (int'(v1o) + int'(v2o) + int'(v3o)) <= 1, 1);

        if (v1o && r1i) cnt1++;
        if (v2o && r2i) cnt2++;
        if (v3o && r3i) cnt3++;
        if (done) begin done_cnt++; done_cyc = cyc; end
        if (aborted) abt_cnt++;
        if (busy) busy_cyc++;
        if (out_fire) last_fire_cyc = cyc;
        if (start && !busy) start_cyc = cyc;

        beat = (seg == 1 && v1i && r1i) || (seg == 2 && v2i && r2i) || (seg == 3 && v3i && r3i);
        if (rst) begin
            m_mode = M_IDLE; m_n = 0; m_b = 0; m_f = 0; m_cw = 0; m_ovr = 0; m_abt = 0;
        end else begin
            old_cw = m_cw;
            m_abt = 1'b0;
            if (out_fire) begin
                if (m_mode == M_IDLE || m_cw == m_n) m_ovr = 1'b1;
                else begin m_f++; m_cw = m_f / CW_BYTES; end
            end
            if (m_mode != M_IDLE && abort) begin
                m_mode = M_IDLE;
                m_abt = 1'b1;
            end else begin
                case (m_mode)
                    M_IDLE: if (start) begin
                        if (num != 0) begin
                            m_n = int'(num); m_b = 0; m_f = 0; m_cw = 0; m_ovr = 0; m_mode = M_RUN;
                        end else m_mode = M_DONE;
                    end
                    M_RUN: begin
                        if (m_b == CW_BEATS * m_n) begin
                            if (old_cw == m_n) m_mode = M_DONE;
                        end else if (beat) m_b++;
                    end
                    default: m_mode = M_IDLE;
                endcase
            end
        end
    endtask

    task automatic step();
        @(negedge clk);
        if (run_cmp) cycle_check();
        cyc++;
        @(posedge clk);
        #1;
        if (bp) begin
            v1i = ($urandom_range(3) != 0); r1i = ($urandom_range(3) != 0);
            v2i = ($urandom_range(3) != 0); r2i = ($urandom_range(3) != 0);
            v3i = ($urandom_range(3) != 0); r3i = ($urandom_range(3) != 0);
        end
        d1i = W1'($urandom);
        d2i = {$urandom, $urandom, $urandom};
        d3i = {$urandom, $urandom, $urandom};
        if (fire_left > 0 && (!fire_rand || $urandom_range(1) == 1)) begin
            out_fire = 1'b1;
            fire_left--;
        end else out_fire = 1'b0;
    endtask

    task automatic start_frame(input int n);
        num = CWW'(n);
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic wait_beats(input int target, input int limit);
        int n = 0;
        while ((cnt1 + cnt2 + cnt3) < target && n < limit) begin step(); n++; end
        chk("wait_beats_in_time", (cnt1 + cnt2 + cnt3) >= target, 1);
    endtask

    task automatic wait_done(input int target, input int limit);
        int n = 0;
        while (done_cnt < target && n < limit) begin step(); n++; end
        chk("wait_done_in_time", done_cnt >= target, 1);
    endtask

    task automatic all_ready();
        bp = 1'b0;
        v1i = 1; r1i = 1; v2i = 1; r2i = 1; v3i = 1; r3i = 1;
    endtask

    task automatic snap();
        b1 = cnt1; b2 = cnt2; b3 = cnt3; bd = done_cnt; ba = abt_cnt; bb = busy_cyc;
    endtask

    initial begin
        int n;
        rst = 1; start = 0; abort = 0; out_fire = 0; num = '0;
        d1i = '0; d2i = '0; d3i = '0;
        all_ready();
        @(posedge clk); #1;
        run_cmp = 1'b1;
        step(); step();
        rst = 0;
        chk("reset_busy", busy, 0);
        chk("reset_overrun", overrun, 0);
        chk("reset_cw_out", cw_out, 0);

        // Single codeword, free-flowing streams, output drained afterwards
        snap();
        start_frame(1);
        wait_beats(b1 + b2 + b3 + 156, 400);
        chk("t1_seg1_beats", cnt1 - b1, 144);
        chk("t1_seg2_beats", cnt2 - b2, 1);
        chk("t1_seg3_beats", cnt3 - b3, 11);
        fire_left = 288; fire_rand = 0;
        wait_done(bd + 1, 600);
        chk("t1_done_latency", done_cyc - last_fire_cyc, 2);
        chk("t1_cw_out", cw_out, 1);

        // Three codewords under random backpressure and random output fires
        snap();
        bp = 1; fire_rand = 1; fire_left = 864;
        start_frame(3);
        wait_done(bd + 1, 20000);
        all_ready();
        fire_rand = 0;
        repeat (4) step();
        chk("t2_seg1_beats", cnt1 - b1, 432);
        chk("t2_seg2_beats", cnt2 - b2, 3);
        chk("t2_seg3_beats", cnt3 - b3, 33);
        chk("t2_done_once", done_cnt - bd, 1);
        chk("t2_cw_out", cw_out, 3);
        chk("t2_no_overrun", overrun, 0);

        // Zero-length frame
        snap();
        start_frame(0);
        repeat (4) step();
        chk("t3_busy_cycles", busy_cyc - bb, 1);
        chk("t3_done_once", done_cnt - bd, 1);
        chk("t3_done_after_start", done_cyc - start_cyc, 1);
        chk("t3_no_beats", (cnt1 - b1) + (cnt2 - b2) + (cnt3 - b3), 0);

        // Abort on the second codeword's parity-A beat, then a clean frame
        snap();
        start_frame(2);
        n = 0;
        while (!(v2o && (cnt2 - b2) == 1) && n < 2000) begin step(); n++; end
        chk("t4_reached_cw2_seg2", v2o && (cnt2 - b2) == 1, 1);
        abort = 1;
        step();
        abort = 0;
        repeat (3) step();
        chk("t4_aborted_once", abt_cnt - ba, 1);
        chk("t4_no_done", done_cnt - bd, 0);
        chk("t4_idle", busy, 0);
        chk("t4_seg1_beats", cnt1 - b1, 288);
        chk("t4_seg2_beats", cnt2 - b2, 2);
        chk("t4_seg3_beats", cnt3 - b3, 11);
        snap();
        start_frame(1);
        wait_beats(b1 + b2 + b3 + 156, 400);
        fire_left = 288;
        wait_done(bd + 1, 600);
        chk("t4b_cw_out", cw_out, 1);
        chk("t4b_no_overrun", overrun, 0);

        // One fire too many; also a start while busy that must be ignored
        snap();
        start_frame(1);
        repeat (5) step();
        num = CWW'(5); start = 1;
        step();
        start = 0;
        wait_beats(b1 + b2 + b3 + 156, 400);
        chk("t5_total_beats", (cnt1 - b1) + (cnt2 - b2) + (cnt3 - b3), 156);
        fire_left = 289;
        wait_done(bd + 1, 600);
        n = 0;
        while (fire_left > 0 && n < 20) begin step(); n++; end
        repeat (4) step();
        chk("t5_overrun_sticky", overrun, 1);
        chk("t5_cw_out", cw_out, 1);
        chk("t5_done_once", done_cnt - bd, 1);
        start_frame(1);
        chk("t5_overrun_cleared", overrun, 0);
        chk("t5_cw_out_cleared", cw_out, 0);

        // Reset in the middle of parity-B
        n = 0;
        while (!v3o && n < 400) begin step(); n++; end
        chk("t6_reached_seg3", v3o, 1);
        step(); step();
        snap();
        rst = 1;
        step();
        rst = 0;
        chk("t6_busy", busy, 0);
        chk("t6_done", done, 0);
        chk("t6_aborted", aborted, 0);
        chk("t6_overrun", overrun, 0);
        chk("t6_cw_out", cw_out, 0);
        chk("t6_gated_valids", {v1o, v2o, v3o}, 3'b000);
        repeat (3) step();
        chk("t6_no_pulses", (done_cnt - bd) + (abt_cnt - ba), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ldpc_concat_scheduler.md
Name: ldpc_concat_scheduler

Overview:
- Sequencing controller in front of the LDPC concatenator's three input streams.
- Gates the streams so exactly one segment passes at a time, in the order first (systematic bytes), second (parity-A words), third (parity-B words), repeated once per codeword.
- Runs a start/busy/done frame protocol with abort.
- Monitors the concatenator output beats to confirm frame completion and detect overrun.

Parameters:
- WIDTH1, 8: first-stream and output width (bits).
- WIDTH2, 96: second-stream width.
- WIDTH3, 96: third-stream width.
- SEG1_WORDS, 144: WIDTH1 words of segment 1 per codeword.
- SEG2_WORDS, 1: WIDTH2 words of segment 2 per codeword.
- SEG3_WORDS, 11: WIDTH3 words of segment 3 per codeword.
- CW_WIDTH, 12: width of the codeword-count fields.

Ports:
- i_clock  in  1  clock.
- i_reset  in  1  synchronous, active-high reset.
- i_start  in  1  frame start request; sampled only in ST_IDLE.
- i_num_codewords  in  CW_WIDTH  codewords in frame; latched on accepted start.
- i_abort  in  1  abandon frame.
- o_busy  out  1  high in every state except ST_IDLE.
- o_done  out  1  1-cycle pulse, frame complete.
- o_aborted  out  1  1-cycle pulse, frame aborted.
- o_overrun  out  1  sticky: unexpected output beat.
- o_cw_out_count  out  CW_WIDTH  codewords fully observed at output.
- i_first_data / i_first_valid / o_first_ready  in/in/out  WIDTH1/1/1  upstream stream 1.
- o_first_data / o_first_valid / i_first_ready  out/out/in  WIDTH1/1/1  to concatenator.
- i_second_*, o_second_*  as above, WIDTH2.
- i_third_*, o_third_*  as above, WIDTH3.
- i_out_fire  in  1  concatenator o_out_valid & i_out_ready.

Behaviour:
- Reset: state ST_IDLE. All outputs 0, including all counters and o_overrun.
- Gating (combinational, zero latency):
  - o_first_valid = i_first_valid & (state==ST_SEG1); o_first_ready = i_first_ready & (state==ST_SEG1).
  - Streams 2 and 3 are gated the same way with ST_SEG2 and ST_SEG3.
  - Data passes through ungated.
  - Beat = gated valid & downstream ready.
- ST_IDLE:
  - Start with i_num_codewords != 0: latch it, clear o_overrun, o_cw_out_count, beat counter and output byte counter; go to ST_SEG1.
  - Start with i_num_codewords == 0: go to ST_DONE (no transfers).
- ST_SEG1: count beats; on beat SEG1_WORDS-1 (counter at max) clear the counter and go to ST_SEG2.
- ST_SEG2: identical to ST_SEG1, with SEG2_WORDS, then go to ST_SEG3.
- ST_SEG3: identical, with SEG3_WORDS. On the last beat:
  - if cw_in_remaining == 1, go to ST_DRAIN;
  - otherwise decrement cw_in_remaining and go to ST_SEG1.
- Output monitor (active in all non-IDLE states):
  - Byte counter counts i_out_fire modulo CW_BYTES = SEG1_WORDS + SEG2_WORDS*WIDTH2/WIDTH1 + SEG3_WORDS*WIDTH3/WIDTH1 (288 with defaults).
  - On wrap, o_cw_out_count increments.
  - i_out_fire when o_cw_out_count == latched count, or in ST_IDLE, sets o_overrun.
- ST_DRAIN: no stream passes. When o_cw_out_count == latched count, go to ST_DONE. Output may complete during the SEG states; ST_DRAIN then exits on its first cycle.
- ST_DONE: o_done=1 for exactly one cycle, then ST_IDLE.
- i_abort:
  - Takes priority over all transitions in any non-IDLE state.
  - Next state ST_IDLE; o_aborted pulses for one cycle; no o_done.
  - Gating drops in the cycle after abort; a beat in the abort cycle itself is allowed.
  - Counters hold until the next start.
- i_abort in ST_IDLE is ignored. i_start while busy is ignored.
- Counter widths: $clog2 of each maximum; decrement and wrap compare against constants. No arithmetic wraps beyond the terminal count.
- i_reset mid-frame: identical to the reset values above, with no pulses.

Decomposition:
- Package ldpc_concat_pkg:
  - state enum (ST_IDLE, ST_SEG1, ST_SEG2, ST_SEG3, ST_DRAIN, ST_DONE);
  - default segment-length constants;
  - CW_BYTES function.
- Sub-module ldpc_concat_out_monitor: output byte/codeword counter and overrun flag.

Test Plan:
- Start, num=1, all streams always valid and ready -> 144 stream-1 beats, 1 stream-2 beat, 11 stream-3 beats, in that order. Feed 288 output fires -> o_done pulse one cycle after the 288th fire is seen in ST_DRAIN; o_cw_out_count=1.
- num=3, random valid/ready backpressure -> total beats 432/3/33; never two gated valids high at once; o_done once.
- num=0 -> no stream beats; o_busy high 1 cycle; o_done the cycle after start.
- Abort on stream-2 beat 0 of codeword 2 (num=2) -> o_aborted pulse, no o_done; new start num=1 completes normally.
- 289 output fires for num=1 -> o_overrun set on the 289th fire; it stays set until the next start.
- Reset asserted mid ST_SEG3 -> next cycle all outputs 0, state ST_IDLE; i_start while busy is ignored, confirmed by count unchanged.
